// File: rtl/device_dna_sequencer.sv
// Sequencer for a serial DNA_PORT-style primitive. It generates a divided DNA clock,
// issues READ then SHIFT, and deserialises the ID into a register exposed as 32-bit words.
module device_dna_sequencer #(
  parameter int DNA_WIDTH = 96,
  parameter int CLK_DIV   = 2,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 dna_clk,
  output logic                 dna_read,
  output logic                 dna_shift,
  input  logic                 dna_dout,
  output logic                 busy,
  output logic                 dna_valid,
  output logic [DNA_WIDTH-1:0] dna_value,
  input  logic                 rd_req,
  input  logic [3:0]           rd_index,
  output logic                 rd_ack,
  output logic                 rd_err,
  output logic [31:0]          rd_data
);

  localparam int NWORDS = (DNA_WIDTH + 31) / 32;
  localparam int CNT_W  = (DNA_WIDTH > 2) ? $clog2(DNA_WIDTH) : 1;
  localparam int PH_W   = (CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;
  localparam logic [PH_W-1:0]  PH_HIGH  = PH_W'(CLK_DIV);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(2 * CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DNA_WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic                 auto_q, auto_d;
  logic [PH_W-1:0]      ph_q, ph_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DNA_WIDTH-1:0] shreg_q, shreg_d;
  logic [DNA_WIDTH-1:0] value_q, value_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 dclk_q, dclk_d;
  logic                 read_q, read_d;
  logic                 shift_q, shift_d;
  logic                 ack_q, ack_d;
  logic                 err_q, err_d;
  logic [31:0]          data_q, data_d;
  logic                 sample_s;
  logic                 idx_ok_s;
  logic [3:0]           idx_sel_s;
  logic [NWORDS*32-1:0] pad_s;
  logic [31:0]          word_s;

  // Insert one captured bit at the end of the register that receives the first bit last.
  function automatic logic [DNA_WIDTH-1:0] shift_in(input logic [DNA_WIDTH-1:0] cur,
                                                    input logic bit_in);
    logic [DNA_WIDTH-1:0] res;
    if (MSB_FIRST) begin
      res = {cur[DNA_WIDTH-2:0], bit_in};
    end else begin
      res = {bit_in, cur[DNA_WIDTH-1:1]};
    end
    return res;
  endfunction

  // Next-state logic for the sequence FSM, period phase, bit counter and capture.
  always_comb begin
    state_d  = state_q;
    auto_d   = auto_q;
    ph_d     = ph_q;
    cnt_d    = cnt_q;
    shreg_d  = shreg_q;
    value_d  = value_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    // The last clk of the high half: the next edge drives dna_clk 1->0 and samples DOUT.
    sample_s = (ph_q == PH_LAST);
    case (state_q)
      ST_IDLE: begin
        if (auto_q || start) begin
          state_d = ST_LOAD;
          auto_d  = 1'b0;
          ph_d    = '0;
          cnt_d   = '0;
          valid_d = 1'b0;
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (sample_s) begin
          state_d = ST_SHIFT;
          ph_d    = '0;
          cnt_d   = cnt_q + CNT_W'(1);
          shreg_d = shift_in(shreg_q, dna_dout);
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      ST_SHIFT: begin
        if (sample_s) begin
          ph_d    = '0;
          shreg_d = shift_in(shreg_q, dna_dout);
          if (cnt_q == CNT_LAST) begin
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        value_d = shreg_q;
        valid_d = 1'b1;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Primitive controls are derived from next state so the flops line up with the phase.
    dclk_d  = ((state_d == ST_LOAD) || (state_d == ST_SHIFT)) && (ph_d >= PH_HIGH);
    read_d  = (state_d == ST_LOAD);
    shift_d = (state_d == ST_SHIFT);
  end

  // Word read response: a single-cycle ack carrying either the word or an error.
  always_comb begin
    pad_s                  = '0;
    pad_s[DNA_WIDTH-1:0]   = value_q;
    idx_ok_s               = ({1'b0, rd_index} < 5'(NWORDS));
    idx_sel_s              = idx_ok_s ? rd_index : 4'd0;
    word_s                 = 32'(pad_s >> {idx_sel_s, 5'd0});
    ack_d                  = rd_req;
    err_d                  = rd_req && (!valid_q || !idx_ok_s);
    if (rd_req && valid_q && idx_ok_s) begin
      data_d = word_s;
    end else begin
      data_d = 32'd0;
    end
  end

  // State and output registers; reset aborts any sequence and re-arms the auto read.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      auto_q  <= 1'b1;
      ph_q    <= '0;
      cnt_q   <= '0;
      shreg_q <= '0;
      value_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      dclk_q  <= 1'b0;
      read_q  <= 1'b0;
      shift_q <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      auto_q  <= auto_d;
      ph_q    <= ph_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      value_q <= value_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      dclk_q  <= dclk_d;
      read_q  <= read_d;
      shift_q <= shift_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end

  assign dna_clk   = dclk_q;
  assign dna_read  = read_q;
  assign dna_shift = shift_q;
  assign busy      = busy_q;
  assign dna_valid = valid_q;
  assign dna_value = value_q;
  assign rd_ack    = ack_q;
  assign rd_err    = err_q;
  assign rd_data   = data_q;

endmodule

// File: tb/tb_device_dna_sequencer.sv
// Directed bench: three sequencer configurations, each driving a behavioural DNA primitive
// that loads its pattern on a READ-qualified dna_clk rise and shifts on a SHIFT-qualified one.
module tb_device_dna_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  logic [3:0] rd_index = 4'd0;

  // ---------------- W=8, CLK_DIV=2, LSB first ----------------
  logic        rst8 = 1'b1, start8 = 1'b0, rd_req8 = 1'b0;
  logic        dclk8, read8, shift8, dout8, busy8, valid8, ack8, err8;
  logic [7:0]  value8;
  logic [31:0] data8;
  logic [7:0]  pat8 = 8'hA5;
  logic [7:0]  m8 = 8'h00;
  int          edges8 = 0, reads8 = 0, shifts8 = 0;

  device_dna_sequencer #(.DNA_WIDTH(8), .CLK_DIV(2), .MSB_FIRST(1'b0)) u_dut8 (
    .clk(clk), .rst(rst8), .start(start8), .dna_clk(dclk8), .dna_read(read8),
    .dna_shift(shift8), .dna_dout(dout8), .busy(busy8), .dna_valid(valid8),
    .dna_value(value8), .rd_req(rd_req8), .rd_index(rd_index), .rd_ack(ack8),
    .rd_err(err8), .rd_data(data8));

  always @(posedge dclk8) begin
    edges8 <= edges8 + 1;
    if (read8) begin
      reads8 <= reads8 + 1;
      m8     <= pat8;
    end else if (shift8) begin
      shifts8 <= shifts8 + 1;
      m8      <= m8 >> 1;
    end
  end
  assign dout8 = m8[0];

  // ---------------- W=96, CLK_DIV=2, LSB first ----------------
  logic        rst96 = 1'b1, rd_req96 = 1'b0;
  logic        dclk96, read96, shift96, dout96, busy96, valid96, ack96, err96;
  logic [95:0] value96;
  logic [31:0] data96;
  logic [95:0] pat96 = 96'h012F1110_C0D111A0_11C0FFEE;
  logic [95:0] m96 = '0;

  device_dna_sequencer #(.DNA_WIDTH(96), .CLK_DIV(2), .MSB_FIRST(1'b0)) u_dut96 (
    .clk(clk), .rst(rst96), .start(1'b0), .dna_clk(dclk96), .dna_read(read96),
    .dna_shift(shift96), .dna_dout(dout96), .busy(busy96), .dna_valid(valid96),
    .dna_value(value96), .rd_req(rd_req96), .rd_index(rd_index), .rd_ack(ack96),
    .rd_err(err96), .rd_data(data96));

  always @(posedge dclk96) begin
    if (read96)       m96 <= pat96;
    else if (shift96) m96 <= m96 >> 1;
  end
  assign dout96 = m96[0];

  // ---------------- W=57, CLK_DIV=1, MSB first ----------------
  logic        rst57 = 1'b1, rd_req57 = 1'b0;
  logic        dclk57, read57, shift57, dout57, busy57, valid57, ack57, err57;
  logic [56:0] value57;
  logic [31:0] data57;
  logic [56:0] pat57 = 57'h0D111A0_C0DE00FF;
  logic [56:0] m57 = '0;

  device_dna_sequencer #(.DNA_WIDTH(57), .CLK_DIV(1), .MSB_FIRST(1'b1)) u_dut57 (
    .clk(clk), .rst(rst57), .start(1'b0), .dna_clk(dclk57), .dna_read(read57),
    .dna_shift(shift57), .dna_dout(dout57), .busy(busy57), .dna_valid(valid57),
    .dna_value(value57), .rd_req(rd_req57), .rd_index(rd_index), .rd_ack(ack57),
    .rd_err(err57), .rd_data(data57));

  always @(posedge dclk57) begin
    if (read57)       m57 <= pat57;
    else if (shift57) m57 <= m57 << 1;
  end
  assign dout57 = m57[56];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int lat, tot, base_e;
    logic hold_ok;

    repeat (3) tick();
    chk("rst8_outputs", {dclk8, read8, shift8, busy8, valid8, ack8, err8}, 7'b0);
    chk("rst8_value", value8, 8'h00);
    chk("rst8_rd_data", data8, 32'h0);
    chk("rst96_outputs", {dclk96, busy96, valid96}, 3'b0);

    // Test 1: auto read out of reset, latency and edge count
    base_e = edges8;
    rst8 = 1'b0;
    tick();
    chk("t1_busy_after_release", busy8, 1'b1);
    chk("t1_read_high", read8, 1'b1);
    repeat (32) tick();
    chk("t1_valid_at_33", valid8, 1'b0);
    tick();
    chk("t1_valid_at_34", valid8, 1'b1);
    chk("t1_value", value8, 8'hA5);
    chk("t1_busy_done", busy8, 1'b0);
    chk("t1_rise_edges", edges8 - base_e, 8);
    chk("t1_read_edges", reads8, 1);
    chk("t1_shift_edges", shifts8, 7);
    chk("t1_clk_idle_low", dclk8, 1'b0);
    rd_req8 = 1'b1; rd_index = 4'd0;
    tick();
    chk("t1_rd0", {ack8, err8, data8}, {2'b10, 32'h000000A5});
    rd_index = 4'd1;
    tick();
    chk("t1_rd1_err", {ack8, err8, data8}, {2'b11, 32'h0});
    rd_req8 = 1'b0;
    tick();
    chk("t1_no_ack", ack8, 1'b0);

    // Test 4: early read error, then reset mid-sequence
    rst8 = 1'b1;
    tick();
    rst8 = 1'b0;
    repeat (11) tick();
    rd_req8 = 1'b1; rd_index = 4'd0;
    tick();
    chk("t4_early_rd", {ack8, err8, data8}, {2'b11, 32'h0});
    rd_req8 = 1'b0;
    tick();
    chk("t4_single_ack", ack8, 1'b0);
    repeat (6) tick();
    rst8 = 1'b1;
    tick();
    chk("t4_in_reset", {dclk8, busy8, valid8}, 3'b000);
    rst8 = 1'b0;
    tick();
    chk("t4_busy_restart", {busy8, valid8}, 2'b10);
    lat = 0;
    for (int n = 2; n <= 60; n++) begin
      tick();
      if (valid8) begin
        lat = n;
        break;
      end
    end
    chk("t4_latency", lat, 34);
    chk("t4_value", value8, 8'hA5);

    // Test 5: re-trigger with a new pattern, second start ignored
    base_e = edges8;
    pat8 = 8'h3C;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tot = 1;
    chk("t5_valid_cleared", {busy8, valid8}, 2'b10);
    chk("t5_value_held", value8, 8'hA5);
    repeat (4) tick();
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tot = 6;
    hold_ok = 1'b1;
    for (int n = 0; n < 60; n++) begin
      tick();
      tot++;
      if (valid8) break;
      if (value8 !== 8'hA5) hold_ok = 1'b0;
    end
    chk("t5_hold_until_done", hold_ok, 1'b1);
    chk("t5_latency", tot, 34);
    chk("t5_value", value8, 8'h3C);
    chk("t5_rise_edges", edges8 - base_e, 8);
    repeat (3) tick();
    chk("t5_stays_idle", {busy8, dclk8, edges8 - base_e}, {2'b00, 32'd8});

    // Test 2: W=96 word reads, read coinciding with DONE, back-to-back reads
    rst96 = 1'b0;
    lat = 0;
    for (int n = 1; n <= 420; n++) begin
      tick();
      if (n == 385) rd_req96 = 1'b1;
      if (valid96) begin
        lat = n;
        break;
      end
    end
    chk("t2_latency", lat, 386);
    chk("t2_rd_during_done", {ack96, err96, data96}, {2'b11, 32'h0});
    chk("t2_value", value96, 96'h012F1110_C0D111A0_11C0FFEE);
    rd_index = 4'd0;
    tick();
    chk("t2_word0", {ack96, err96, data96}, {2'b10, 32'h11C0FFEE});
    rd_index = 4'd1;
    tick();
    chk("t2_word1", {ack96, err96, data96}, {2'b10, 32'hC0D111A0});
    rd_index = 4'd2;
    tick();
    chk("t2_word2", {ack96, err96, data96}, {2'b10, 32'h012F1110});
    rd_index = 4'd3;
    tick();
    chk("t2_word3_err", {ack96, err96, data96}, {2'b11, 32'h0});
    rd_req96 = 1'b0;
    tick();
    chk("t2_ack_drops", ack96, 1'b0);

    // Test 3: W=57, MSB first, CLK_DIV=1
    rst57 = 1'b0;
    lat = 0;
    for (int n = 1; n <= 150; n++) begin
      tick();
      if (valid57) begin
        lat = n;
        break;
      end
    end
    chk("t3_latency", lat, 116);
    chk("t3_value", value57, 57'h0D111A0_C0DE00FF);
    rd_req57 = 1'b1; rd_index = 4'd0;
    tick();
    chk("t3_word0", {ack57, err57, data57}, {2'b10, 32'hC0DE00FF});
    rd_index = 4'd1;
    tick();
    chk("t3_word1", {ack57, err57, data57}, {2'b10, 32'h00D111A0});
    rd_index = 4'd2;
    tick();
    chk("t3_word2_err", {ack57, err57, data57}, {2'b11, 32'h0});
    rd_req57 = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
